// File: rtl/data_fetch_seq_pkg.sv
// Shared state encoding and command constants for the BRAM data-fetch sequencer.
package data_fetch_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        FIN
    } fseq_state_t;

    localparam logic OP_LOAD     = 1'b0;
    localparam logic OP_STORE    = 1'b1;
    localparam int   STORE_BEATS = 4;

    // LOAD length in beats for a DIMEN code: 0/1/2/3 -> 2/4/8/16.
    function automatic logic [4:0] beats(input logic [1:0] dimen);
        return 5'd2 << dimen;
    endfunction

endpackage

// File: rtl/data_fetch_seq_if.sv
// Command/status handshake with the control unit plus the fetch-stage control and PE load strobe.
interface data_fetch_seq_if #(
    parameter int ADDR_W = 4
);
    logic              start;
    logic              op;
    logic [1:0]        dimen_in;
    logic [ADDR_W-1:0] base_in;
    logic [1:0]        pe_sel_in;
    logic [1:0]        pe_sub_in;
    logic              busy;
    logic              done;
    logic              err;

    logic [1:0]        dimen;
    logic [ADDR_W-1:0] address;
    logic [1:0]        pe_sel;
    logic              pe_sel_4;
    logic              pe_sel_2x2;
    logic              addr_rst;
    logic              addr_start;
    logic              wraddr_start;
    logic              fetch_done;
    logic              store_done;
    logic              pe_ld_vld;
    logic [ADDR_W-1:0] pe_ld_idx;

    modport master (
        output start, op, dimen_in, base_in, pe_sel_in, pe_sub_in, fetch_done, store_done,
        input  busy, done, err, dimen, address, pe_sel, pe_sel_4, pe_sel_2x2,
               addr_rst, addr_start, wraddr_start, pe_ld_vld, pe_ld_idx
    );

    modport slave (
        input  start, op, dimen_in, base_in, pe_sel_in, pe_sub_in, fetch_done, store_done,
        output busy, done, err, dimen, address, pe_sel, pe_sel_4, pe_sel_2x2,
               addr_rst, addr_start, wraddr_start, pe_ld_vld, pe_ld_idx
    );

endinterface

// File: rtl/data_fetch_seq.sv
// Runs one LOAD/STORE through the BRAM fetch stage; DONE lands N+2 cycles after START for an
// N-beat LOAD, 5 for a STORE, TIMEOUT+1 on abort. START is only sampled while idle.
module data_fetch_seq #(
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    data_fetch_seq_if.slave bus
);
    import data_fetch_seq_pkg::*;

    localparam int TO_W = $clog2(TIMEOUT);

    fseq_state_t       r_state;
    fseq_state_t       w_next;
    logic              r_op;
    logic [1:0]        r_dimen;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_pe_sel;
    logic [1:0]        r_pe_sub;
    logic [ADDR_W-1:0] r_beat;
    logic [TO_W-1:0]   r_tcnt;
    logic              r_abort;
    logic              r_ld_vld;
    logic [ADDR_W-1:0] r_ld_idx;

    logic w_done_in;
    logic w_timeout;
    logic w_busy;
    logic w_done;
    logic w_err;
    logic w_addr_rst;
    logic w_addr_start;
    logic w_wraddr;

    always_comb begin
        w_next       = r_state;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        w_err        = 1'b0;
        w_addr_rst   = 1'b0;
        w_addr_start = 1'b0;
        w_wraddr     = 1'b0;
        w_done_in    = (r_op == OP_STORE) ? bus.store_done : bus.fetch_done;
        w_timeout    = (r_tcnt == TO_W'(TIMEOUT - 1));

        case (r_state)
            IDLE: begin
                w_addr_rst = 1'b1;
                if (bus.start) begin
                    w_next = RUN;
                end
            end
            RUN: begin
                w_busy       = 1'b1;
                w_addr_start = ~w_done_in;
                w_wraddr     = r_op;
                // A done flag on the timeout cycle still counts as a clean finish.
                if (w_done_in) begin
                    w_next = (r_op == OP_STORE) ? FIN : DRAIN;
                end else if (w_timeout) begin
                    w_next = FIN;
                end
            end
            DRAIN: begin
                w_busy = 1'b1;
                w_next = FIN;
            end
            FIN: begin
                w_busy     = 1'b1;
                w_done     = 1'b1;
                w_addr_rst = 1'b1;
                w_err      = r_abort;
                w_next     = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_op     <= OP_LOAD;
            r_dimen  <= '0;
            r_addr   <= '0;
            r_pe_sel <= '0;
            r_pe_sub <= '0;
            r_beat   <= '0;
            r_tcnt   <= '0;
            r_abort  <= 1'b0;
            r_ld_vld <= 1'b0;
            r_ld_idx <= '0;
        end else begin
            r_state <= w_next;
            // Read data trails the address by one cycle, so the strobe is delayed to match.
            r_ld_vld <= (r_state == RUN) && (r_op == OP_LOAD);
            r_ld_idx <= r_beat;

            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_op     <= bus.op;
                        r_dimen  <= bus.dimen_in;
                        r_addr   <= bus.base_in;
                        r_pe_sel <= bus.pe_sel_in;
                        r_pe_sub <= bus.pe_sub_in;
                        r_beat   <= '0;
                        r_tcnt   <= '0;
                        r_abort  <= 1'b0;
                    end
                end
                RUN: begin
                    if (w_addr_start) begin
                        r_beat <= r_beat + ADDR_W'(1);
                    end
                    r_tcnt <= r_tcnt + TO_W'(1);
                    if (!w_done_in && w_timeout) begin
                        r_abort <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy         = w_busy;
    assign bus.done         = w_done;
    assign bus.err          = w_err;
    assign bus.addr_rst     = w_addr_rst;
    assign bus.addr_start   = w_addr_start;
    assign bus.wraddr_start = w_wraddr;
    assign bus.dimen        = r_dimen;
    assign bus.address      = r_addr;
    assign bus.pe_sel       = r_pe_sel;
    assign bus.pe_sel_4     = r_pe_sub[1];
    assign bus.pe_sel_2x2   = r_pe_sub[0];
    assign bus.pe_ld_vld    = r_ld_vld;
    assign bus.pe_ld_idx    = r_ld_idx;

endmodule

// File: tb/tb_data_fetch_seq.sv
// Bench for data_fetch_seq: fetch-counter + BRAM environment and a per-command transaction model.
module tb_data_fetch_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    data_fetch_seq_if #(.ADDR_W(4)) bus ();

    data_fetch_seq #(.ADDR_W(4), .TIMEOUT(32)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    logic [3:0] fcnt;
    logic       kill_fetch;
    logic       mem_load;
    logic [7:0] pe_dout;
    logic [7:0] rd_q;
    logic [7:0] mem     [16];
    logic [7:0] ref_mem [16];
    int         n_chk = 0;
    int         n_err = 0;

    // Fetch stage: address counter plus BRAM with one cycle of read latency.
    always @(posedge clk or posedge rst) begin
        if (rst)                 fcnt <= 4'd0;
        else if (bus.addr_rst)   fcnt <= 4'd0;
        else if (bus.addr_start) fcnt <= fcnt + 4'd1;
    end

    assign bus.fetch_done = !kill_fetch && ({1'b0, fcnt} == ((5'd2 << bus.dimen) - 5'd1));
    assign bus.store_done = (fcnt == 4'd3);

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 16; i++) mem[i] <= ref_mem[i];
        end else if (bus.wraddr_start) begin
            mem[bus.address + fcnt] <= pe_dout;
        end
        rd_q <= mem[bus.address + fcnt];
    end

    task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Issue one command from an IDLE negedge; returns at the negedge of the following IDLE cycle.
    task automatic run_cmd(input bit op, input logic [1:0] dm, input logic [3:0] base,
                           input logic [1:0] ps, input logic [1:0] sub, input bit kill,
                           input bit hold);
        int         n;
        int         exp_done;
        int         cyc;
        int         vld_n;
        int         as_n;
        int         wr_n;
        int         busy_n;
        int         stray;
        bit         sel_bad;
        bit         done_seen;
        logic [7:0] word;
        logic [3:0] a;

        n        = op ? 4 : (2 << dm);
        exp_done = kill ? 33 : (op ? 5 : n + 2);
        word     = 8'($urandom);
        cyc = 0; vld_n = 0; as_n = 0; wr_n = 0; busy_n = 0; stray = 0;
        sel_bad = 1'b0; done_seen = 1'b0;

        kill_fetch     = kill;
        pe_dout        = word;
        bus.start      = 1'b1;
        bus.op         = op;
        bus.dimen_in   = dm;
        bus.base_in    = base;
        bus.pe_sel_in  = ps;
        bus.pe_sub_in  = sub;

        while (!done_seen && cyc < 80) begin
            @(negedge clk);
            if (!hold) bus.start = 1'b0;
            cyc++;
            busy_n += int'(bus.busy);
            as_n   += int'(bus.addr_start);
            wr_n   += int'(bus.wraddr_start);
            if ({bus.dimen, bus.address, bus.pe_sel, bus.pe_sel_4, bus.pe_sel_2x2} !== {dm, base, ps, sub})
                sel_bad = 1'b1;
            if (bus.pe_ld_vld) begin
                a = base + 4'(vld_n);
                check_val("ld_idx", bus.pe_ld_idx, vld_n % 16);
                check_val("ld_dat", rd_q, ref_mem[a]);
                vld_n++;
            end
            if (bus.done) begin
                done_seen = 1'b1;
                check_val("done_cyc", cyc, exp_done);
                check_val("err", bus.err, kill);
            end else if (bus.err) begin
                stray++;
            end
        end

        if (!done_seen) begin
            check_val("done_seen", 0, 1);
            bus.start = 1'b0;
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
            return;
        end

        check_val("busy_cnt", busy_n, exp_done);
        check_val("vld_cnt", vld_n, op ? 0 : (kill ? 32 : n));
        check_val("addr_start_cnt", as_n, kill ? 32 : n - 1);
        check_val("wraddr_cnt", wr_n, op ? 4 : 0);
        check_val("sel_hold", sel_bad, 0);
        check_val("stray_err", stray, 0);

        if (op) begin
            for (int i = 0; i < 4; i++) begin
                a = base + 4'(i);
                ref_mem[a] = word;
            end
            for (int i = 0; i < 4; i++) begin
                a = base + 4'(i);
                check_val("st_mem", mem[a], ref_mem[a]);
            end
        end

        kill_fetch = 1'b0;
        @(negedge clk);
        check_val("idle", {bus.busy, bus.done, bus.err, bus.addr_rst}, 4'b0001);
    endtask

    logic       r_op;
    logic [1:0] r_dm;
    logic [3:0] r_base;
    logic [1:0] r_ps;
    logic [1:0] r_sub;
    bit         r_kill;
    bit         r_hold;
    int         quiet;

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.op = 1'b0; bus.dimen_in = '0; bus.base_in = '0;
        bus.pe_sel_in = '0; bus.pe_sub_in = '0;
        kill_fetch = 1'b0; pe_dout = '0; mem_load = 1'b1;
        for (int i = 0; i < 16; i++) ref_mem[i] = 8'($urandom);
        repeat (3) @(negedge clk);
        mem_load = 1'b0;

        check_val("rst_ctl", {bus.busy, bus.done, bus.err, bus.addr_rst, bus.addr_start,
                              bus.wraddr_start, bus.pe_ld_vld}, 7'b0001000);
        check_val("rst_fields", {bus.dimen, bus.address, bus.pe_sel, bus.pe_sel_4,
                                 bus.pe_sel_2x2, bus.pe_ld_idx}, 0);
        rst = 1'b0;
        @(negedge clk);

        run_cmd(1'b0, 2'd2, 4'd4, 2'd0, 2'b00, 1'b0, 1'b0);
        run_cmd(1'b1, 2'd0, 4'd13, 2'd3, 2'b01, 1'b0, 1'b0);
        run_cmd(1'b0, 2'd0, 4'd7, 2'd1, 2'b10, 1'b0, 1'b0);
        run_cmd(1'b0, 2'd1, 4'd2, 2'd2, 2'b11, 1'b1, 1'b0);
        run_cmd(1'b0, 2'd3, 4'd0, 2'd0, 2'b00, 1'b0, 1'b0);
        run_cmd(1'b0, 2'd1, 4'd9, 2'd1, 2'b01, 1'b0, 1'b1);
        run_cmd(1'b1, 2'd2, 4'd6, 2'd2, 2'b10, 1'b0, 1'b1);
        run_cmd(1'b0, 2'd0, 4'd14, 2'd3, 2'b11, 1'b0, 1'b0);

        // Reset in the middle of a LOAD, at fetch beat 3.
        bus.start = 1'b1; bus.op = 1'b0; bus.dimen_in = 2'd3; bus.base_in = 4'd9;
        bus.pe_sel_in = 2'd2; bus.pe_sub_in = 2'b11;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check_val("pre_rst_busy", bus.busy, 1);
        rst = 1'b1;
        #1;
        check_val("arst_ctl", {bus.busy, bus.done, bus.err, bus.addr_rst, bus.addr_start,
                               bus.wraddr_start, bus.pe_ld_vld}, 7'b0001000);
        check_val("arst_fields", {bus.dimen, bus.address, bus.pe_sel, bus.pe_sel_4,
                                  bus.pe_sel_2x2, bus.pe_ld_idx}, 0);
        @(negedge clk);
        rst = 1'b0;
        quiet = 0;
        repeat (4) begin
            @(negedge clk);
            quiet += int'(bus.done | bus.busy);
        end
        check_val("post_rst_quiet", quiet, 0);
        run_cmd(1'b0, 2'd1, 4'd11, 2'd1, 2'b10, 1'b0, 1'b0);

        for (int k = 0; k < 24; k++) begin
            r_op   = 1'($urandom_range(0, 1));
            r_dm   = 2'($urandom_range(0, 3));
            r_base = 4'($urandom_range(0, 15));
            r_ps   = 2'($urandom_range(0, 3));
            r_sub  = 2'($urandom_range(0, 3));
            r_kill = !r_op && ($urandom_range(0, 5) == 0);
            r_hold = (k != 23) && ($urandom_range(0, 2) == 0);
            run_cmd(r_op, r_dm, r_base, r_ps, r_sub, r_kill, r_hold);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", n_err, n_chk);
        $fatal(1);
    end

endmodule
